// File: rtl/param_shift_unit.sv
// Iterative log-shifter (SLL/SRA/SRL/ROR) with a start/done handshake, one shift-amount bit per cycle.
// Optional macro SHIFT_EARLY_EXIT_EN finishes as soon as no higher shift-amount bits remain set.
module param_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } stateT;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SHAMT_W:0] fullWidth = (SHAMT_W+1)'(WIDTH);

    stateT              state;
    logic [WIDTH-1:0]   workReg;
    logic [1:0]         opReg;
    logic               signBit;
    // Remaining shift-amount bits; bit 0 always belongs to the current stage.
    logic [SHAMT_W-1:0] shamtRem;
    // One-hot stage weight 2^k, doubling every SHIFT cycle.
    logic [SHAMT_W-1:0] stepAmt;

    logic [WIDTH-1:0]   nextWork;
    logic [SHAMT_W:0]   backAmt;
    logic               lastStage;

    always_comb begin
        nextWork = workReg;
        backAmt  = fullWidth - {1'b0, stepAmt};
        if (shamtRem[0]) begin
            unique case (opReg)
                OP_SLL: nextWork = workReg << stepAmt;
                OP_SRA: nextWork = (workReg >> stepAmt) | ({WIDTH{signBit}} << backAmt);
                OP_SRL: nextWork = workReg >> stepAmt;
                OP_ROR: nextWork = (workReg >> stepAmt) | (workReg << backAmt);
                default: nextWork = workReg;
            endcase
        end
    end

    always_comb begin
        lastStage = stepAmt[SHAMT_W-1];
`ifdef SHIFT_EARLY_EXIT_EN
        if ((shamtRem >> 1) == '0) begin
            lastStage = 1'b1;
        end
`else
        lastStage = stepAmt[SHAMT_W-1];
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            workReg  <= '0;
            opReg    <= '0;
            signBit  <= 1'b0;
            shamtRem <= '0;
            stepAmt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        workReg  <= data_in;
                        opReg    <= op;
                        signBit  <= data_in[WIDTH-1];
                        shamtRem <= shamt;
                        stepAmt  <= SHAMT_W'(1);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    workReg  <= nextWork;
                    shamtRem <= shamtRem >> 1;
                    stepAmt  <= stepAmt << 1;
                    if (lastStage) begin
                        result <= nextWork;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
